stream_mem_ctrl: RTL and testbench
==================================

Name: stream_mem_ctrl

Overview:
- Single-clock streaming FIFO controller that masters an external two-port register-array memory.
- Drives the write-port side (aB/cenB/d) from an input valid/ready stream.
- Drives the read-port side (aA/cenA) and consumes the registered read data q onto an output valid/ready stream.
- Memory instance sits outside this block; clkA and clkB of the memory are both tied to clk.

Parameters:
- DEPTH, 64, number of words in the attached memory (need not be a power of two).
- LOGDEPTH, 6, address width; requires 2^LOGDEPTH >= DEPTH.
- WORDWIDTH, 16, data word width.

Ports:
- clk  input  1  single clock; drives this block and both memory ports.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all state.
- in_valid  input  1  input word present.
- in_ready  output  1  controller can accept a word.
- in_data  input  WORDWIDTH  input word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WORDWIDTH  output word; combinationally equal to mem_q.
- occupancy  output  LOGDEPTH+1  words held, memory plus output stage.
- mem_aB  output  LOGDEPTH  memory write address.
- mem_cenB  output  1  memory write enable, active-low.
- mem_d  output  WORDWIDTH  memory write data.
- mem_aA  output  LOGDEPTH  memory read address.
- mem_cenA  output  1  memory read enable, active-low.
- mem_q  input  WORDWIDTH  registered memory read data. It updates at a posedge where mem_cenA=0 and holds otherwise.

Behaviour:
- State: wr_ptr and rd_ptr (LOGDEPTH bits each), count (LOGDEPTH+1 bits, words in memory excluding the output stage), out_valid register.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, out_valid=0.
  - While rst=1, mem_cenA=1 and mem_cenB=1 are forced, in_ready=0 and occupancy=0.
  - Reset mid-transfer discards all data.
- in_ready = (count != DEPTH) & ~flush & ~rst. This is a pure function of registered count, with no combinational path from out_ready.
- push = in_valid & in_ready.
  - mem_cenB = ~push; mem_aB = wr_ptr; mem_d = in_data.
  - On push, wr_ptr advances; DEPTH-1 wraps to 0.
- pop_issue = (count != 0) & (~out_valid | out_ready) & ~flush.
  - mem_cenA = ~pop_issue; mem_aA = rd_ptr.
  - On pop_issue, rd_ptr advances with the same wrap rule.
- out_valid next value:
  - 1 if pop_issue.
  - Else 0 if out_ready.
  - Else hold.
  - Transfer occurs on out_valid & out_ready.
- out_data = mem_q. This is valid because the memory output register holds until the next read, and a read is issued only when the output stage is empty or being consumed.
- count next value: count + push - pop_issue.
  - Push and pop_issue in the same cycle leave count unchanged.
  - Push and pop_issue never target the same slot in that cycle, because pop_issue needs count>0.
- occupancy = count + out_valid.
- Latency: a word pushed at edge k can be read at edge k+1, so out_valid is high after edge k+1. That is 2 cycles from in_valid to out_valid when the controller is empty.
- Throughput: 1 word/cycle sustained with out_ready held high.
- Full: count==DEPTH gives in_ready=0. Total capacity is DEPTH+1 including the output stage.
- Empty: count==0 gives no read issued; out_valid falls after the pending word is consumed.
- Backpressure: while out_valid=1 and out_ready=0, no read is issued and mem_q/out_data stay stable.
- Flush (flush=1, sampled at posedge): pointers, count and out_valid clear to 0.
  - During the flush cycle, push and pop_issue are suppressed, so mem_cenA=mem_cenB=1.
  - Flush with rst: rst dominates.
- Wrap: pointers wrap at DEPTH-1 independently of 2^LOGDEPTH. For example, with DEPTH=5 and LOGDEPTH=3, the address sequence is 0..4,0.

Test Plan:
- Reset/idle: assert rst mid-stream with count=3 -> immediately in_ready=0, out_valid=0, mem_cenA=mem_cenB=1, occupancy=0; after release, in_ready=1.
- Latency/order: DEPTH=4, push 0xA1,0xA2,0xA3 back-to-back with out_ready=1 -> out_valid rises 2 cycles after the first push; out_data reads 0xA1,0xA2,0xA3 on consecutive cycles; occupancy returns to 0.
- Full/backpressure: DEPTH=4, out_ready=0, push 6 words -> 5 accepted (4 in memory + 1 in output stage); in_ready=0 with occupancy=5; out_data stays at word 1 and mem_cenA stays 1 throughout.
- Simultaneous push/pop at full: from the full state, raise out_ready for one cycle while in_valid=1 -> the push is refused that cycle (in_ready is registered-count based); the next cycle push is accepted; count stays 4.
- Wrap-around: DEPTH=5, LOGDEPTH=3, stream 12 words with out_ready toggling 1,0 -> mem_aB and mem_aA each cycle 0,1,2,3,4,0; output order is preserved with no loss or duplication.
- Flush: with occupancy=3, pulse flush -> next cycle occupancy=0, out_valid=0; a subsequent push of 0x55 appears at out_data 2 cycles later with mem_aB=0.

Source files
------------

// File: rtl/stream_mem_ctrl.sv
// stream_mem_ctrl: single-clock streaming FIFO controller mastering an
// external two-port register-array memory. The write port (aB/cenB/d) is
// fed from an input valid/ready stream. The read port (aA/cenA) feeds an
// output valid/ready stream whose data is the memory's registered output q.
// The memory sits outside this block; both of its clocks are tied to clk.
module stream_mem_ctrl #(
    parameter int DEPTH     = 64,
    parameter int LOGDEPTH  = 6,
    parameter int WORDWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORDWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORDWIDTH-1:0] out_data,
    output logic [LOGDEPTH:0]    occupancy,
    output logic [LOGDEPTH-1:0]  mem_aB,
    output logic                 mem_cenB,
    output logic [WORDWIDTH-1:0] mem_d,
    output logic [LOGDEPTH-1:0]  mem_aA,
    output logic                 mem_cenA,
    input  logic [WORDWIDTH-1:0] mem_q
);

    // Count constants sized to the count register.
    localparam logic [LOGDEPTH:0]   CNT_FULL = (LOGDEPTH+1)'(DEPTH);
    localparam logic [LOGDEPTH:0]   CNT_ONE  = (LOGDEPTH+1)'(1);
    localparam logic [LOGDEPTH:0]   CNT_ZERO = (LOGDEPTH+1)'(0);
    // Pointer constants; the last valid address need not be 2^LOGDEPTH-1.
    localparam logic [LOGDEPTH-1:0] PTR_LAST = LOGDEPTH'(DEPTH-1);
    localparam logic [LOGDEPTH-1:0] PTR_ONE  = LOGDEPTH'(1);
    localparam logic [LOGDEPTH-1:0] PTR_ZERO = LOGDEPTH'(0);

    // Advance a memory pointer, wrapping at the last populated word.
    function automatic logic [LOGDEPTH-1:0] ptr_next(input logic [LOGDEPTH-1:0] ptr);
        logic [LOGDEPTH-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    // State registers.
    logic [LOGDEPTH-1:0] wr_ptr_r;
    logic [LOGDEPTH-1:0] rd_ptr_r;
    logic [LOGDEPTH:0]   count_r;
    logic                out_valid_r;

    // Next-state values and per-cycle qualifiers.
    logic [LOGDEPTH-1:0] wr_ptr_nxt_s;
    logic [LOGDEPTH-1:0] rd_ptr_nxt_s;
    logic [LOGDEPTH:0]   count_nxt_s;
    logic                out_valid_nxt_s;
    logic                in_ready_s;
    logic                push_s;
    logic                pop_s;

    // Accept and read-issue qualifiers. in_ready looks only at the
    // registered count so nothing from out_ready reaches it. A read is issued
    // only when the output stage is empty or being drained this cycle, which
    // keeps mem_q stable while a word waits there.
    always_comb begin
        in_ready_s = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        if (rst || flush) begin
            in_ready_s = 1'b0;
            push_s     = 1'b0;
            pop_s      = 1'b0;
        end else begin
            in_ready_s = (count_r != CNT_FULL);
            push_s     = in_valid && (count_r != CNT_FULL);
            pop_s      = (count_r != CNT_ZERO) && (!out_valid_r || out_ready);
        end
    end

    // Pointer next state: each pointer steps on its own port's access.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nxt_s = ptr_next(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = ptr_next(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Word count next state: simultaneous push and read cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Output stage: filled by a read, emptied by a consumer handshake,
    // otherwise held.
    always_comb begin
        out_valid_nxt_s = out_valid_r;
        if (pop_s) begin
            out_valid_nxt_s = 1'b1;
        end else if (out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // State update: async reset, flush clears everything synchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Stream-side outputs. out_data is the memory's own output register.
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = mem_q;
    assign occupancy = count_r + {{LOGDEPTH{1'b0}}, out_valid_r};

    // Memory-side outputs; enables are active-low.
    assign mem_aB   = wr_ptr_r;
    assign mem_cenB = ~push_s;
    assign mem_d    = in_data;
    assign mem_aA   = rd_ptr_r;
    assign mem_cenA = ~pop_s;

endmodule

// File: tb/tb_stream_mem_ctrl.sv
// Self-checking bench for stream_mem_ctrl. Two instances share one input
// stream: dut4 (DEPTH=4, LOGDEPTH=2) and dut5 (DEPTH=5, LOGDEPTH=3, non
// power-of-two depth). Each has its own memory model, and each is compared
// against a queue-based reference model of the FIFO.
module tb_stream_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [15:0] in_data;

    logic        ready4, ov4, cena4, cenb4;
    logic [15:0] od4, d4, q4;
    logic [2:0]  occ4;
    logic [1:0]  aa4, ab4;

    logic        ready5, ov5, cena5, cenb5;
    logic [15:0] od5, d5, q5;
    logic [3:0]  occ5;
    logic [2:0]  aa5, ab5;

    stream_mem_ctrl #(.DEPTH(4), .LOGDEPTH(2), .WORDWIDTH(16)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ready4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .occupancy(occ4),
        .mem_aB(ab4), .mem_cenB(cenb4), .mem_d(d4),
        .mem_aA(aa4), .mem_cenA(cena4), .mem_q(q4)
    );

    stream_mem_ctrl #(.DEPTH(5), .LOGDEPTH(3), .WORDWIDTH(16)) dut5 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ready5), .in_data(in_data),
        .out_valid(ov5), .out_ready(out_ready), .out_data(od5),
        .occupancy(occ5),
        .mem_aB(ab5), .mem_cenB(cenb5), .mem_d(d5),
        .mem_aA(aa5), .mem_cenA(cena5), .mem_q(q5)
    );

    // External two-port register arrays with registered read data.
    logic [15:0] mem4 [4];
    logic [15:0] mem5 [8];
    always @(posedge clk) begin
        if (!cenb4) mem4[ab4] <= d4;
        if (!cena4) q4 <= mem4[aa4];
    end
    always @(posedge clk) begin
        if (!cenb5) mem5[ab5] <= d5;
        if (!cena5) q5 <= mem5[aa5];
    end

    // Observable outputs of one instance, widened to common sizes.
    typedef struct packed {
        logic        ir;
        logic        ov;
        logic        cena;
        logic        cenb;
        logic [3:0]  occ;
        logic [2:0]  aa;
        logic [2:0]  ab;
        logic [15:0] od;
    } obs_t;

    // Reference model: words in memory as a queue, an output-stage slot,
    // and running push/read totals from which addresses follow (mod DEPTH).
    typedef logic [15:0] word_q_t [$];
    word_q_t     mq [2];
    logic        m_ov [2];
    logic [15:0] m_od [2];
    int          m_push [2];
    int          m_pop [2];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int dep(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic void model_clear(input int i);
        mq[i].delete();
        m_ov[i]   = 1'b0;
        m_od[i]   = 16'h0000;
        m_push[i] = 0;
        m_pop[i]  = 0;
    endfunction

    // Expected outputs for the current inputs and model state.
    function automatic obs_t predict(input int i);
        obs_t e;
        int   n;
        logic pu, po;
        e = '0;
        n = mq[i].size();
        if (rst) begin
            e.cena = 1'b1;
            e.cenb = 1'b1;
            return e;
        end
        e.ir   = (n != dep(i)) && !flush;
        pu     = in_valid && e.ir;
        po     = (n != 0) && (!m_ov[i] || out_ready) && !flush;
        e.ov   = m_ov[i];
        e.cenb = !pu;
        e.cena = !po;
        e.occ  = 4'(n + (m_ov[i] ? 1 : 0));
        e.aa   = 3'(m_pop[i] % dep(i));
        e.ab   = 3'(m_push[i] % dep(i));
        e.od   = m_ov[i] ? m_od[i] : 16'h0000;
        return e;
    endfunction

    function automatic obs_t sample(input int i);
        obs_t a;
        if (i == 0) begin
            a.ir = ready4; a.ov = ov4; a.cena = cena4; a.cenb = cenb4;
            a.occ = {1'b0, occ4}; a.aa = {1'b0, aa4}; a.ab = {1'b0, ab4};
            a.od = ov4 ? od4 : 16'h0000;
        end else begin
            a.ir = ready5; a.ov = ov5; a.cena = cena5; a.cenb = cenb5;
            a.occ = occ5; a.aa = aa5; a.ab = ab5;
            a.od = ov5 ? od5 : 16'h0000;
        end
        return a;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ir=%b ov=%b cenA=%b cenB=%b occ=%0d aA=%0d aB=%0d od=%h",
                         o.ir, o.ov, o.cena, o.cenb, o.occ, o.aa, o.ab, o.od);
    endfunction

    // Advance the model across one clock edge using the inputs held there.
    function automatic void model_step(input int i);
        obs_t        e;
        logic [15:0] w;
        if (rst || flush) begin
            model_clear(i);
        end else begin
            e = predict(i);
            if (!e.cena) begin
                w = mq[i].pop_front();
                m_ov[i] = 1'b1;
                m_od[i] = w;
                m_pop[i]++;
            end else if (out_ready) begin
                m_ov[i] = 1'b0;
            end
            if (!e.cenb) begin
                mq[i].push_back(in_data);
                m_push[i]++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic test_reset();
        obs_t e, a;
        rst = 1'b1;
        drive(1'b1, 16'h1111, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                e = predict(i); a = sample(i); n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL reset dut%0d cyc %0d: got %s, expected %s", i, c, fmt(a), fmt(e));
                end
            end
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (ready4 !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready: got %b expected 1", ready4);
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 16'(16'h0A00 + c), 1'b0, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                e = predict(i); a = sample(i); n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL reset_fill dut%0d cyc %0d: got %s, expected %s", i, c, fmt(a), fmt(e));
                end
            end
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (occ4 !== 3'd4) begin
            n_err++; $display("FAIL reset_pre_occ: got %0d expected 4", occ4);
        end
        drive(1'b1, 16'h2222, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ready4, ov4, cena4, cenb4, occ4} !== {1'b0, 1'b0, 1'b1, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL reset_midstream: got ir=%b ov=%b cenA=%b cenB=%b occ=%0d expected 0 0 1 1 0",
                     ready4, ov4, cena4, cenb4, occ4);
        end
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (ready4 !== 1'b1 || occ4 !== 3'd0) begin
            n_err++; $display("FAIL reset_after: got ir=%b occ=%0d expected 1 0", ready4, occ4);
        end
    endtask

    task automatic test_latency();
        obs_t        e, a;
        int          first_ov;
        logic [15:0] got [$];
        logic [15:0] words [3];
        words[0] = 16'h00A1; words[1] = 16'h00A2; words[2] = 16'h00A3;
        first_ov = -1;
        for (int c = 0; c < 8; c++) begin
            if (c < 3) drive(1'b1, words[c], 1'b1, 1'b0);
            else       drive(1'b0, 16'h0000, 1'b1, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                e = predict(i); a = sample(i); n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL latency dut%0d cyc %0d: got %s, expected %s", i, c, fmt(a), fmt(e));
                end
            end
            if (ov4 === 1'b1 && first_ov < 0) first_ov = c;
            if (ov4 === 1'b1) got.push_back(od4);
            tick();
        end
        n_cmp++;
        if (first_ov != 2) begin
            n_err++; $display("FAIL latency_first_valid: got cycle %0d expected 2", first_ov);
        end
        n_cmp++;
        if (got.size() != 3) begin
            n_err++; $display("FAIL latency_count: got %0d words expected 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (got[k] !== words[k]) begin
                    n_err++; $display("FAIL latency_order[%0d]: got %h expected %h", k, got[k], words[k]);
                end
            end
        end
        n_cmp++;
        if (occ4 !== 3'd0) begin
            n_err++; $display("FAIL latency_occ: got %0d expected 0", occ4);
        end
    endtask

    task automatic test_full();
        obs_t e, a;
        int   accepted;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 16'(16'h00B0 + c), 1'b0, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                e = predict(i); a = sample(i); n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL full dut%0d cyc %0d: got %s, expected %s", i, c, fmt(a), fmt(e));
                end
            end
            if (ready4 === 1'b1) accepted++;
            if (c >= 2) begin
                n_cmp++;
                if (ov4 !== 1'b1 || od4 !== 16'h00B0 || cena4 !== 1'b1) begin
                    n_err++;
                    $display("FAIL full_stable cyc %0d: got ov=%b od=%h cenA=%b expected 1 00b0 1", c, ov4, od4, cena4);
                end
            end
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (accepted != 5) begin
            n_err++; $display("FAIL full_accepted: got %0d expected 5", accepted);
        end
        n_cmp++;
        if (ready4 !== 1'b0 || occ4 !== 3'd5) begin
            n_err++; $display("FAIL full_state: got ir=%b occ=%0d expected 0 5", ready4, occ4);
        end
        n_cmp++;
        if (ready5 !== 1'b0 || occ5 !== 4'd6) begin
            n_err++; $display("FAIL full_state5: got ir=%b occ=%0d expected 0 6", ready5, occ5);
        end
    endtask

    task automatic test_full_pop();
        obs_t e, a;
        drive(1'b1, 16'h00C1, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (ready4 !== 1'b0 || cena4 !== 1'b0 || cenb4 !== 1'b1) begin
            n_err++;
            $display("FAIL fullpop_refuse: got ir=%b cenA=%b cenB=%b expected 0 0 1", ready4, cena4, cenb4);
        end
        tick();
        drive(1'b1, 16'h00C1, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (ready4 !== 1'b1 || cenb4 !== 1'b0) begin
            n_err++; $display("FAIL fullpop_accept: got ir=%b cenB=%b expected 1 0", ready4, cenb4);
        end
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (occ4 !== 3'd5 || ready4 !== 1'b0) begin
            n_err++; $display("FAIL fullpop_occ: got occ=%0d ir=%b expected 5 0", occ4, ready4);
        end
        for (int c = 0; c < 9; c++) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                e = predict(i); a = sample(i); n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL drain dut%0d cyc %0d: got %s, expected %s", i, c, fmt(a), fmt(e));
                end
            end
            tick();
        end
        n_cmp++;
        if (occ4 !== 3'd0 || occ5 !== 4'd0) begin
            n_err++; $display("FAIL drain_empty: got occ4=%0d occ5=%0d expected 0 0", occ4, occ5);
        end
    endtask

    task automatic test_wrap();
        obs_t        e, a;
        logic [15:0] sent [$];
        logic [15:0] got [$];
        int          wr_k, rd_k;
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        wr_k = 0; rd_k = 0;
        for (int c = 0; c < 80 && got.size() < 12; c++) begin
            drive(sent.size() < 12, 16'(16'h0100 + sent.size()), (c % 2) == 0, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                e = predict(i); a = sample(i); n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL wrap dut%0d cyc %0d: got %s, expected %s", i, c, fmt(a), fmt(e));
                end
            end
            if (cenb5 === 1'b0) begin
                n_cmp++;
                if (ab5 !== 3'(wr_k % 5)) begin
                    n_err++; $display("FAIL wrap_aB write %0d: got %0d expected %0d", wr_k, ab5, wr_k % 5);
                end
                sent.push_back(in_data);
                wr_k++;
            end
            if (cena5 === 1'b0) begin
                n_cmp++;
                if (aa5 !== 3'(rd_k % 5)) begin
                    n_err++; $display("FAIL wrap_aA read %0d: got %0d expected %0d", rd_k, aa5, rd_k % 5);
                end
                rd_k++;
            end
            if (ov5 === 1'b1 && out_ready) got.push_back(od5);
            tick();
        end
        n_cmp++;
        if (got.size() != 12) begin
            n_err++; $display("FAIL wrap_count: got %0d words expected 12", got.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_cmp++;
                if (got[k] !== 16'(16'h0100 + k)) begin
                    n_err++; $display("FAIL wrap_order[%0d]: got %h expected %h", k, got[k], 16'(16'h0100 + k));
                end
            end
        end
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                e = predict(i); a = sample(i); n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL wrap_drain dut%0d cyc %0d: got %s, expected %s", i, c, fmt(a), fmt(e));
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 16'(16'h00D0 + c), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (occ4 !== 3'd3) begin
            n_err++; $display("FAIL flush_pre_occ: got %0d expected 3", occ4);
        end
        drive(1'b1, 16'h00EE, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if (cena4 !== 1'b1 || cenb4 !== 1'b1 || ready4 !== 1'b0) begin
            n_err++;
            $display("FAIL flush_cycle: got cenA=%b cenB=%b ir=%b expected 1 1 0", cena4, cenb4, ready4);
        end
        tick();
        drive(1'b1, 16'h0055, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (occ4 !== 3'd0 || ov4 !== 1'b0 || ab4 !== 2'd0 || cenb4 !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after: got occ=%0d ov=%b aB=%0d cenB=%b expected 0 0 0 0", occ4, ov4, ab4, cenb4);
        end
        tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (ov4 !== 1'b0 || cena4 !== 1'b0) begin
            n_err++; $display("FAIL flush_read_issue: got ov=%b cenA=%b expected 0 0", ov4, cena4);
        end
        tick();
        #1;
        n_cmp++;
        if (ov4 !== 1'b1 || od4 !== 16'h0055) begin
            n_err++; $display("FAIL flush_refill: got ov=%b od=%h expected 1 0055", ov4, od4);
        end
        tick();
    endtask

    task automatic test_random();
        obs_t e, a;
        int   vprob, rprob;
        for (int c = 0; c < 400; c++) begin
            vprob = ((c / 50) % 2 == 0) ? 80 : 30;
            rprob = ((c / 70) % 2 == 0) ? 30 : 85;
            drive($urandom_range(0, 99) < vprob, 16'($urandom), $urandom_range(0, 99) < rprob,
                  $urandom_range(0, 47) == 0);
            rst = ($urandom_range(0, 119) == 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                e = predict(i); a = sample(i); n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL random dut%0d cyc %0d: got %s, expected %s", i, c, fmt(a), fmt(e));
                end
            end
            tick();
            rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        model_clear(0);
        model_clear(1);
        @(negedge clk);
        test_reset();
        test_latency();
        test_full();
        test_full_pop();
        test_wrap();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
